// File: rtl/readout_ser_tx.sv
// rtl/readout_ser_tx.sv - Per-flavour readout link transmitter: hit FIFO, token, delayed 27-bit serial frame.
module readout_ser_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter int TX_DLY     = 4,
  parameter bit GRAY_TS    = 1'b1
) (
  input  logic                          clk_bx,
  input  logic                          rst_n,
  input  logic                          hit_valid,
  input  logic [5:0]                    hit_col,
  input  logic [8:0]                    hit_row,
  input  logic [5:0]                    hit_le,
  input  logic [5:0]                    hit_te,
  output logic                          hit_ready,
  input  logic                          freeze,
  input  logic                          read,
  output logic                          token,
  output logic                          data_out,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          err_read_empty,
  output logic                          err_read_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = (TX_DLY > 2) ? $clog2(TX_DLY) : 1;
  localparam int FW = 27;

  typedef enum logic [1:0] {IDLE, WAIT, SHIFT} state_t;

  state_t          state;
  logic [FW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [AW:0]     level_nxt;
  logic            ready_en;
  logic            read_q;
  logic [FW-1:0]   shreg;
  logic [4:0]      bit_cnt;
  logic [DW-1:0]   dly_cnt;
  logic [5:0]      le_tx;
  logic [5:0]      te_tx;
  logic            full;
  logic            wr_en;
  logic            rd_edge;
  logic            start;
  logic            pop;

  // ready_en keeps hit_ready low while reset is asserted and on the edge that releases it
  assign full       = (count == (AW+1)'(FIFO_DEPTH));
  assign hit_ready  = ready_en & ~full & ~freeze;
  assign wr_en      = hit_valid & hit_ready;
  assign rd_edge    = read & ~read_q;
  assign tx_busy    = (state != IDLE);
  assign start      = rd_edge & ~tx_busy;
  assign pop        = start & (count != '0);
  assign level_nxt  = count + (AW+1)'(wr_en) - (AW+1)'(pop);
  assign fifo_level = count;
  assign le_tx      = GRAY_TS ? (hit_le ^ (hit_le >> 1)) : hit_le;
  assign te_tx      = GRAY_TS ? (hit_te ^ (hit_te >> 1)) : hit_te;

  // TX_DLY must be >= 2: the frame MSB is driven TX_DLY-1 edges after the load edge
  always_ff @(posedge clk_bx or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      token          <= 1'b0;
      ready_en       <= 1'b0;
      read_q         <= 1'b0;
      state          <= IDLE;
      shreg          <= '0;
      bit_cnt        <= '0;
      dly_cnt        <= '0;
      data_out       <= 1'b0;
      err_read_empty <= 1'b0;
      err_read_busy  <= 1'b0;
    end else begin
      read_q   <= read;
      ready_en <= 1'b1;
      count    <= level_nxt;
      token    <= (level_nxt != '0);
      if (wr_en) begin
        mem[wr_ptr] <= {hit_col, hit_row, le_tx, te_tx};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (rd_edge && tx_busy) err_read_busy <= 1'b1;

      case (state)
        IDLE: begin
          data_out <= 1'b0;
          if (start) begin
            shreg   <= pop ? mem[rd_ptr] : '0;
            dly_cnt <= '0;
            state   <= WAIT;
            if (!pop) err_read_empty <= 1'b1;
          end
        end
        WAIT: begin
          if (dly_cnt == DW'(TX_DLY - 2)) begin
            data_out <= shreg[FW-1];
            shreg    <= {shreg[FW-2:0], 1'b0};
            bit_cnt  <= '0;
            state    <= SHIFT;
          end else begin
            dly_cnt <= dly_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (bit_cnt == 5'd26) begin
            data_out <= 1'b0;
            state    <= IDLE;
          end else begin
            data_out <= shreg[FW-1];
            shreg    <= {shreg[FW-2:0], 1'b0};
            bit_cnt  <= bit_cnt + 1'b1;
          end
        end
        default: begin
          data_out <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_readout_ser_tx.sv
// tb/tb_readout_ser_tx.sv - Scoreboard bench for readout_ser_tx with a queue-based reference model.
module tb_readout_ser_tx;

  localparam int DEPTH  = 4;
  localparam int TX_DLY = 4;

  logic        clk_bx = 1'b0;
  logic        rst_n = 1'b0;
  logic        hit_valid = 1'b0;
  logic [5:0]  hit_col = '0;
  logic [8:0]  hit_row = '0;
  logic [5:0]  hit_le = '0;
  logic [5:0]  hit_te = '0;
  logic        freeze = 1'b0;
  logic        read = 1'b0;
  logic        hit_ready, token, data_out, tx_busy, err_read_empty, err_read_busy;
  logic [2:0]  fifo_level;

  int tests = 0;
  int fails = 0;

  logic [26:0] mfifo[$];
  logic [26:0] exp_q[$];
  int cyc = 0;
  int busy_until = -1;
  bit m_en = 0, m_read_q = 0, m_err_empty = 0, m_err_busy = 0;

  readout_ser_tx #(.FIFO_DEPTH(DEPTH), .TX_DLY(TX_DLY), .GRAY_TS(1'b1)) dut (
    .clk_bx(clk_bx), .rst_n(rst_n), .hit_valid(hit_valid), .hit_col(hit_col),
    .hit_row(hit_row), .hit_le(hit_le), .hit_te(hit_te), .hit_ready(hit_ready),
    .freeze(freeze), .read(read), .token(token), .data_out(data_out),
    .tx_busy(tx_busy), .fifo_level(fifo_level), .err_read_empty(err_read_empty),
    .err_read_busy(err_read_busy)
  );

  always #5 clk_bx = ~clk_bx;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [26:0] frame_of(input logic [5:0] c, input logic [8:0] r,
                                           input logic [5:0] l, input logic [5:0] t);
    return {c, r, l ^ (l >> 1), t ^ (t >> 1)};
  endfunction

  task automatic model_reset();
    mfifo.delete();
    exp_q.delete();
    busy_until = -1;
    m_en = 0; m_read_q = 0; m_err_empty = 0; m_err_busy = 0;
  endtask

  task automatic rand_hit();
    hit_col = 6'($urandom); hit_row = 9'($urandom);
    hit_le  = 6'($urandom); hit_te  = 6'($urandom);
  endtask

  // One clock: check state seen after the previous edge, then advance the model through the next edge
  task automatic step();
    bit exp_ready, rd_e, do_w;
    @(negedge clk_bx);
    exp_ready = m_en && (mfifo.size() < DEPTH) && !freeze;
    chk("hit_ready", hit_ready, exp_ready);
    chk("fifo_level", fifo_level, mfifo.size());
    chk("token", token, mfifo.size() != 0);
    chk("tx_busy", tx_busy, cyc < busy_until);
    chk("err_read_empty", err_read_empty, m_err_empty);
    chk("err_read_busy", err_read_busy, m_err_busy);
    do_w = hit_valid && exp_ready;
    @(posedge clk_bx);
    cyc++;
    rd_e = read && !m_read_q;
    m_read_q = read;
    if (rd_e) begin
      if (cyc <= busy_until) m_err_busy = 1;
      else begin
        if (mfifo.size() != 0) exp_q.push_back(mfifo.pop_front());
        else begin exp_q.push_back('0); m_err_empty = 1; end
        busy_until = cyc + TX_DLY + 26;
      end
    end
    if (do_w) mfifo.push_back(frame_of(hit_col, hit_row, hit_le, hit_te));
    m_en = 1;
    #1;
  endtask

  task automatic idle(input int n);
    hit_valid = 0; read = 0; freeze = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic read_pulse(input int len);
    read = 1;
    for (int i = 0; i < len; i++) step();
    read = 0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_data_out", data_out, 0);
    chk("rst_tx_busy", tx_busy, 0);
    chk("rst_token", token, 0);
    chk("rst_fifo_level", fifo_level, 0);
    chk("rst_hit_ready", hit_ready, 0);
    chk("rst_err_empty", err_read_empty, 0);
    chk("rst_err_busy", err_read_busy, 0);
  endtask

  // Monitor: whenever a frame starts, collect its 27 bits and compare against the scoreboard
  initial begin : monitor
    logic [26:0] got;
    logic [26:0] exp;
    bit ab;
    forever begin
      @(negedge clk_bx);
      if (rst_n && tx_busy) begin
        ab = 0;
        got = '0;
        for (int i = 0; i < TX_DLY - 1; i++) begin
          chk("wait_zero", data_out, 0);
          @(negedge clk_bx);
          if (!rst_n) begin ab = 1; break; end
        end
        for (int k = 0; k < 27 && !ab; k++) begin
          got = {got[25:0], data_out};
          @(negedge clk_bx);
          if (!rst_n) ab = 1;
        end
        if (!ab) begin
          if (exp_q.size() == 0) chk("frame_unexpected", 1, 0);
          else begin
            exp = exp_q.pop_front();
            chk("frame", got, exp);
          end
          chk("end_data_zero", data_out, 0);
          chk("end_idle", tx_busy, 0);
        end
      end else if (rst_n) begin
        chk("idle_data_zero", data_out, 0);
      end
    end
  end

  initial begin : stim
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk_bx);
    #1 rst_n = 1;
    model_reset();
    idle(2);

    // single known hit, 2-cycle read pulse
    hit_col = 6'd5; hit_row = 9'd100; hit_le = 6'd3; hit_te = 6'd9;
    chk("known_frame_in_queue_model", frame_of(hit_col, hit_row, hit_le, hit_te),
        27'b000101_001100100_000010_001101);
    hit_valid = 1; step(); hit_valid = 0;
    read_pulse(2);
    idle(34);

    // three random hits, reads spaced 32 cycles apart
    hit_valid = 1;
    for (int i = 0; i < 3; i++) begin rand_hit(); step(); end
    hit_valid = 0;
    for (int i = 0; i < 3; i++) begin read_pulse(1); idle(31); end
    idle(5);

    // freeze blocks acceptance, release accepts on the next edge
    freeze = 1; hit_valid = 1; rand_hit();
    for (int i = 0; i < 10; i++) step();
    freeze = 0; step(); hit_valid = 0;
    chk("freeze_release_level", fifo_level, 1);

    // second read edge during a frame is ignored
    hit_valid = 1; rand_hit(); step(); hit_valid = 0;
    read_pulse(1); idle(9); read_pulse(1);
    idle(40);
    read_pulse(1); idle(40);

    // read with empty FIFO sends zeros
    read_pulse(1); idle(40);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      hit_valid = 1'($urandom_range(0, 1));
      rand_hit();
      freeze = ($urandom_range(0, 7) == 0);
      if (read) read = $urandom_range(0, 1) != 0;
      else      read = ($urandom_range(0, 24) == 0);
      step();
    end
    idle(40);
    chk("scoreboard_drained", exp_q.size(), 0);

    // fill to depth, start a frame, reset at bit 12
    hit_valid = 1;
    for (int i = 0; i < DEPTH + 2; i++) begin rand_hit(); step(); end
    hit_valid = 0;
    read_pulse(1);
    for (int i = 0; i < TX_DLY - 1 + 12; i++) step();
    rst_n = 0;
    #1;
    check_reset_outputs();
    model_reset();
    repeat (2) @(posedge clk_bx);
    #1 rst_n = 1;
    idle(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
